vnu: RTL

Variable node unit for the layered min-sum LDPC decoder; the counterpart to the check node unit. Each transaction takes one variable node's channel LLR and its D incoming check-to-variable messages r. It produces D outgoing variable-to-check messages q (extrinsic: total minus own r) and a hard decision. Two-stage pipeline with valid/ready handshake on both sides; r/q packing matches the check node unit so the two connect directly.

---
 rtl/ldpc_pkg.sv | 15 +
 rtl/sat_sym.sv | 15 +
 rtl/vnu.sv | 71 +++++++
 3 files changed

// File: rtl/ldpc_pkg.sv
// ldpc_pkg: shared LDPC helpers (clog2, symmetric saturation, default message width)
package ldpc_pkg;
  localparam int msg_w_default = 8;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int n = 1; n < v; n <<= 1) r++;
    return r;
  endfunction
  function automatic int sat_int(input int v, input int w);
    int lim;
    lim = (1 << (w - 1)) - 1;
    return v > lim ? lim : (v < -lim ? -lim : v);
  endfunction
endpackage

// File: rtl/sat_sym.sv
// sat_sym: clamp signed in_w value x to +/-(2^(out_w-1)-1) on y
module sat_sym
  import ldpc_pkg::*;
#(
  parameter int in_w  = 10,
  parameter int out_w = 8
) (
  input  logic signed [in_w-1:0]  x,
  input  logic                    unused_tie,
  output logic signed [out_w-1:0] y
);
  logic unused;
  assign unused = unused_tie;
  assign y = out_w'(sat_int(int'(x), out_w));
endmodule

// File: rtl/vnu.sv
// vnu: variable node unit, ch + r[D] -> extrinsic q[D] and hard decision hd, 2-stage valid/ready pipeline
module vnu
  import ldpc_pkg::*;
#(
  parameter int D      = 3,
  parameter int data_w = msg_w_default,
  parameter int tag_w  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  first,
  input  logic [data_w-1:0]     ch,
  input  logic [data_w*D-1:0]   r,
  input  logic [tag_w-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [data_w*D-1:0]   q,
  output logic                  hd,
  output logic [tag_w-1:0]      out_tag
);
  localparam int sum_w = data_w + clog2(D + 1);
  logic                    s1_valid, s2_free;
  logic signed [sum_w-1:0] sum_in, s1_sum;
  logic [data_w*D-1:0]     rr_in, s1_rr, q_nx;
  logic [tag_w-1:0]        s1_tag;
  assign s2_free  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_free;
  assign rr_in    = first ? '0 : r;
  always_comb begin
    sum_in = sum_w'(signed'(ch));
    for (int i = 0; i < D; i++) sum_in += sum_w'(signed'(rr_in[i*data_w +: data_w]));
  end
  for (genvar i = 0; i < D; i++) begin : g_sat
    sat_sym #(.in_w(sum_w), .out_w(data_w)) u_sat (
      .x          (s1_sum - sum_w'(signed'(s1_rr[i*data_w +: data_w]))),
      .unused_tie (1'b0),
      .y          (q_nx[i*data_w +: data_w])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sum    <= '0;
      s1_rr     <= '0;
      s1_tag    <= '0;
      out_valid <= 1'b0;
      q         <= '0;
      hd        <= 1'b0;
      out_tag   <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_sum <= sum_in;
          s1_rr  <= rr_in;
          s1_tag <= in_tag;
        end
      end
      if (s2_free) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          q       <= q_nx;
          hd      <= s1_sum < 0;
          out_tag <= s1_tag;
        end
      end
    end
  end
endmodule
